cache_victim_sel: RTL and testbench

Replacement-way controller for the set-associative cache refill path. It takes a refill request carrying the set's valid and lock bits and returns exactly one victim way. Invalid unlocked ways are preferred. Otherwise it picks pseudo-randomly from an internal 8-bit LFSR, and the LFSR is stepped only when a random pick is consumed. It sits between the cache miss FSM, which issues requests, and the refill/writeback sequencer, which consumes victims.

---
 rtl/cache_victim_sel.sv | 168 ++++++++++++++++
 tb/tb_cache_victim_sel.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: picks one victim way for a cache refill.
//
// Invalid unlocked ways are taken first, lowest index winning. When every
// unlocked way is valid, the scan starts at the index given by the low bits
// of an 8-bit XNOR LFSR and wraps around. The LFSR only advances when such a
// random pick is actually made.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i/ready_o  refill request handshake
//   valid_ways_i         per-way valid bits of the missed set (sampled on accept)
//   lock_ways_i          per-way lock bits, 1 = never replace (sampled on accept)
//   victim_valid_o/ready_i  result handshake
//   victim_way_oh_o      one-hot victim, zero when no candidate exists
//   victim_way_bin_o     binary victim index, zero when no candidate exists
//   victim_invalid_o     chosen way was invalid, no writeback required
//   victim_none_o        all ways locked, no victim
module cache_victim_sel #(
  parameter int unsigned WAYS = 4,
  parameter logic [7:0]  SEED = 8'h00,
  localparam int unsigned BinW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [WAYS-1:0] valid_ways_i,
  input  logic [WAYS-1:0] lock_ways_i,
  output logic            victim_valid_o,
  input  logic            victim_ready_i,
  output logic [WAYS-1:0] victim_way_oh_o,
  output logic [BinW-1:0] victim_way_bin_o,
  output logic            victim_invalid_o,
  output logic            victim_none_o
);

  // Elaboration-time parameter checks.
  if (WAYS < 2 || WAYS > 8 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
    $fatal(1, "cache_victim_sel: WAYS must be a power of 2 in 2..8");
  end
  if (SEED == 8'hFF) begin : g_bad_seed
    $fatal(1, "cache_victim_sel: SEED 8'hFF is the XNOR LFSR lockup state");
  end

  typedef enum logic [1:0] {StIdle, StPick, StResp} state_e;

  state_e          state_q, state_d;
  logic [WAYS-1:0] valid_q, valid_d;
  logic [WAYS-1:0] lock_q, lock_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [WAYS-1:0] oh_q, oh_d;
  logic [BinW-1:0] bin_q, bin_d;
  logic            inv_q, inv_d;
  logic            none_q, none_d;

  // Victim selection from the captured set state.
  logic [WAYS-1:0] cand, free;
  logic [WAYS-1:0] pick_oh;
  logic [BinW-1:0] pick_bin;
  logic [BinW-1:0] idx;
  logic            pick_inv, pick_none, pick_rand, found;
  logic            lfsr_fb;

  assign lfsr_fb = ~(lfsr_q[7] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[1]);

  always_comb begin
    cand      = ~lock_q;
    free      = cand & ~valid_q;
    pick_oh   = '0;
    pick_bin  = '0;
    pick_inv  = 1'b0;
    pick_none = 1'b0;
    pick_rand = 1'b0;
    found     = 1'b0;
    idx       = '0;
    if (|free) begin
      pick_inv = 1'b1;
      for (int unsigned i = 0; i < WAYS; i++) begin
        if (!found && free[i]) begin
          found    = 1'b1;
          pick_bin = BinW'(i);
        end
      end
    end else if (cand == '0) begin
      pick_none = 1'b1;
    end else begin
      pick_rand = 1'b1;
      // Index arithmetic wraps modulo WAYS because WAYS is a power of 2.
      for (int unsigned i = 0; i < WAYS; i++) begin
        idx = lfsr_q[BinW-1:0] + BinW'(i);
        if (!found && cand[idx]) begin
          found    = 1'b1;
          pick_bin = idx;
        end
      end
    end
    if (!pick_none) begin
      pick_oh[pick_bin] = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    lock_d  = lock_q;
    lfsr_d  = lfsr_q;
    oh_d    = oh_q;
    bin_d   = bin_q;
    inv_d   = inv_q;
    none_d  = none_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          valid_d = valid_ways_i;
          lock_d  = lock_ways_i;
          state_d = StPick;
        end
      end
      StPick: begin
        oh_d    = pick_oh;
        bin_d   = pick_bin;
        inv_d   = pick_inv;
        none_d  = pick_none;
        if (pick_rand) begin
          lfsr_d = {lfsr_q[6:0], lfsr_fb};
        end
        state_d = StResp;
      end
      StResp: begin
        if (victim_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      valid_q <= '0;
      lock_q  <= '0;
      lfsr_q  <= SEED;
      oh_q    <= '0;
      bin_q   <= '0;
      inv_q   <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      lfsr_q  <= lfsr_d;
      oh_q    <= oh_d;
      bin_q   <= bin_d;
      inv_q   <= inv_d;
      none_q  <= none_d;
    end
  end

  assign req_ready_o      = (state_q == StIdle);
  assign victim_valid_o   = (state_q == StResp);
  assign victim_way_oh_o  = oh_q;
  assign victim_way_bin_o = bin_q;
  assign victim_invalid_o = inv_q;
  assign victim_none_o    = none_q;

endmodule

// File: tb/tb_cache_victim_sel.sv
// Self-checking bench for cache_victim_sel (WAYS=4, SEED=0): directed steps
// followed by random requests, compared against a behavioural model.
module tb_cache_victim_sel;

  localparam int unsigned W  = 4;
  localparam int unsigned BW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  valid_ways = '0;
  logic [W-1:0]  lock_ways = '0;
  logic          victim_valid;
  logic          victim_ready = 1'b0;
  logic [W-1:0]  oh;
  logic [BW-1:0] bin;
  logic          inv;
  logic          none;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state and expected result.
  int            lfsr_m = 0;
  logic [W-1:0]  exp_oh = '0;
  logic [BW-1:0] exp_bin = '0;
  logic          exp_inv = 1'b0;
  logic          exp_none = 1'b0;

  cache_victim_sel #(.WAYS(W), .SEED(8'h00)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .valid_ways_i     (valid_ways),
    .lock_ways_i      (lock_ways),
    .victim_valid_o   (victim_valid),
    .victim_ready_i   (victim_ready),
    .victim_way_oh_o  (oh),
    .victim_way_bin_o (bin),
    .victim_invalid_o (inv),
    .victim_none_o    (none)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int lfsr_step(input int q);
    int fb;
    fb = ~((q >> 7) ^ (q >> 3) ^ (q >> 2) ^ (q >> 1)) & 1;
    return ((q << 1) | fb) & 8'hFF;
  endfunction

  // Victim choice from the rules: free ways first, else a wrapped scan from
  // the LFSR low bits over unlocked ways.
  task automatic model_pick(input logic [W-1:0] v, input logic [W-1:0] l);
    int cand, free, r, j;
    cand = ~int'(l) & ((1 << W) - 1);
    free = cand & ~int'(v);
    j = -1;
    exp_oh = '0; exp_bin = '0; exp_inv = 1'b0; exp_none = 1'b0;
    if (free != 0) begin
      exp_inv = 1'b1;
      for (int k = W - 1; k >= 0; k--) if (free[k]) j = k;
    end else if (cand == 0) begin
      exp_none = 1'b1;
    end else begin
      r = lfsr_m % W;
      for (int k = W - 1; k >= 0; k--) if (cand[(r + k) % W]) j = (r + k) % W;
      lfsr_m = lfsr_step(lfsr_m);
    end
    if (!exp_none) begin
      exp_bin = BW'(j);
      exp_oh  = W'(1 << j);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_oh"},   32'(oh),   32'(exp_oh));
    chk({tag, "_bin"},  32'(bin),  32'(exp_bin));
    chk({tag, "_inv"},  32'(inv),  32'(exp_inv));
    chk({tag, "_none"}, 32'(none), 32'(exp_none));
  endtask

  // Present a request in IDLE; returns #1 into the PICK cycle.
  task automatic issue(input string tag, input logic [W-1:0] v, input logic [W-1:0] l);
    chk({tag, "_rdy_idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    valid_ways = v;
    lock_ways  = l;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    valid_ways = W'($urandom);
    lock_ways  = W'($urandom);
    model_pick(v, l);
    chk({tag, "_rdy_pick"}, 32'(req_ready), 32'd0);
    chk({tag, "_vv_pick"},  32'(victim_valid), 32'd0);
  endtask

  // Step into RESP, hold backpressure for `hold` cycles, then handshake.
  task automatic collect(input string tag, input int hold);
    @(posedge clk); #1;
    chk({tag, "_vv"}, 32'(victim_valid), 32'd1);
    check_out(tag);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vv"},  32'(victim_valid), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
      check_out({tag, "_hold"});
    end
    victim_ready = 1'b1;
    @(posedge clk); #1;
    victim_ready = 1'b0;
    chk({tag, "_vv_idle"},  32'(victim_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(req_ready), 32'd1);
    check_out({tag, "_kept"});
  endtask

  initial begin
    // Reset state.
    #1;
    chk("rst_rdy", 32'(req_ready), 32'd1);
    chk("rst_vv",  32'(victim_valid), 32'd0);
    check_out("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_rdy", 32'(req_ready), 32'd1);

    // Invalid preference, LFSR untouched.
    issue("inv", 4'b1011, 4'b0000);   collect("inv", 0);
    issue("after_inv", 4'b1111, 4'b0000); collect("after_inv", 0);  // way 0, lfsr 01
    // Locks with wrap-around.
    issue("lock1", 4'b1111, 4'b0010); collect("lock1", 0);          // way 2, lfsr 03
    issue("lock2", 4'b1111, 4'b1000); collect("lock2", 0);          // wrap to 0, lfsr 06
    // All locked leaves the LFSR alone.
    issue("alllock", 4'b1111, 4'b1111); collect("alllock", 0);
    issue("post_lock", 4'b1111, 4'b0000); collect("post_lock", 0);  // way 2, lfsr 0D

    // Backpressure with a pending request held during PICK/RESP.
    issue("bp", 4'b1111, 4'b0000);
    req_valid  = 1'b1;
    valid_ways = 4'b0111;
    lock_ways  = 4'b0001;
    collect("bp", 5);
    @(posedge clk); #1;                // pending request taken now
    req_valid = 1'b0;
    model_pick(4'b0111, 4'b0001);
    chk("bp_pend_rdy", 32'(req_ready), 32'd0);
    collect("bp_pend", 0);
    chk("bp_pend_oh_nz", 32'(oh != '0), 32'd1);

    // Async reset during PICK.
    issue("arst_pick", 4'b1111, 4'b0000);
    rst_n = 1'b0; #1;
    lfsr_m = 0; exp_oh = '0; exp_bin = '0; exp_inv = 1'b0; exp_none = 1'b0;
    chk("arst_pick_vv",  32'(victim_valid), 32'd0);
    chk("arst_pick_rdy", 32'(req_ready), 32'd1);
    check_out("arst_pick");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Async reset during RESP with a nonzero result.
    issue("arst_resp", 4'b1011, 4'b0000);
    @(posedge clk); #1;
    chk("arst_resp_vv_pre", 32'(victim_valid), 32'd1);
    rst_n = 1'b0; #1;
    lfsr_m = 0; exp_oh = '0; exp_bin = '0; exp_inv = 1'b0; exp_none = 1'b0;
    chk("arst_resp_vv",  32'(victim_valid), 32'd0);
    chk("arst_resp_rdy", 32'(req_ready), 32'd1);
    check_out("arst_resp");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random sequence from SEED: victims 0,1,3,2.
    for (int i = 0; i < 4; i++) begin
      issue("seq", 4'b1111, 4'b0000);
      collect("seq", 0);
    end
    chk("seq_lfsr_model", 32'(lfsr_m), 32'h0D);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] v, l;
      v = ($urandom_range(0, 2) == 0) ? W'($urandom) : 4'b1111;
      l = ($urandom_range(0, 3) == 0) ? W'($urandom) : 4'b0000;
      issue("rnd", v, l);
      collect("rnd", $urandom_range(0, 2));
      chk("rnd_onehot_xor_none", 32'(($countones(oh) == 1) != none), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
